// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a 2-entry skid
// buffer (main + skid), synchronous flush and control zeroing on bubbles.
// Optional feature macro: PIPE_STAGE_STATS_EN enables the stall and bubble
// statistics counters; without it stat_stall/stat_bubbl are tied to zero.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32,
  parameter int NDATA  = 3,
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [STAT_W-1:0]       stat_stall,
  output logic [STAT_W-1:0]       stat_bubbl
);

  localparam int DW = NDATA * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              accept, drain;
  logic              load_main_in, load_main_skid, load_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DW-1:0]     main_data, skid_data;

  // Handshake flags come straight from the state register, so in_ready has
  // no combinational path from in_valid or out_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  // State register.
  always_ff @(posedge clk) begin
    if (!clrn) state <= EMPTY;
    else       state <= state_nx;
  end

  // Next-state and entry load enables; flush wins over accept/drain.
  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx     = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nx  = SKID;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nx = EMPTY;
          end
        end
        SKID: begin
          if (drain) begin
            state_nx       = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Entry storage; main data is kept across drains and flushes so out_data
  // holds its last value while the stage is empty.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Saturating stall/bubble counters; only reset clears them.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      stat_stall <= '0;
      stat_bubbl <= '0;
    end else begin
      if (out_valid && !out_ready && (stat_stall != '1))
        stat_stall <= stat_stall + STAT_W'(1);
      if (!out_valid && (stat_bubbl != '1))
        stat_bubbl <= stat_bubbl + STAT_W'(1);
    end
  end
`else
  assign stat_stall = '0;
  assign stat_bubbl = '0;
`endif

endmodule
